// File: rtl/hs_link_pkg.sv
// Shared types and default sizes for the hs_link transmitter slice.
// Optional timeout support is selected with the HS_LINK_TIMEOUT_EN macro.
package hs_link_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        REL   = 2'd2,
        DRAIN = 2'd3
    } hs_state_t;

    localparam int HS_DATA_W_DEF  = 8;
    localparam int HS_DEPTH_DEF   = 4;
    localparam int HS_TIMEOUT_DEF = 64;

endpackage

// File: rtl/hs_link_fifo.sv
// Single-clock FIFO feeding the link FSM; head word is visible combinationally
// so the FSM can capture it into its output register on the pop edge.
module hs_fifo
    import hs_link_pkg::*;
#(
    parameter int DATA_W = HS_DATA_W_DEF,
    parameter int DEPTH  = HS_DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [DATA_W-1:0]       wdata,
    input  logic                    pop,
    output logic [DATA_W-1:0]       rdata,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW:0]       count_reg;
    logic              push_en;
    logic              pop_en;

    // Guard against overflow/underflow even if the caller misbehaves.
    assign push_en = push && !full;
    assign pop_en  = pop && (count_reg != '0);

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_en, pop_en})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rdata = mem[rd_ptr_reg];
    assign count = count_reg;
    assign full  = (count_reg == (AW + 1)'(DEPTH));

endmodule

// File: rtl/hs_link_tx.sv
// Four-phase send/ack link transmitter: FIFO-buffered words, delivered-word
// counter and, with HS_LINK_TIMEOUT_EN, a per-phase handshake timeout.
module hs_link_tx
    import hs_link_pkg::*;
#(
    parameter int DATA_W  = HS_DATA_W_DEF,
    parameter int DEPTH   = HS_DEPTH_DEF,
    parameter int TIMEOUT = HS_TIMEOUT_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    send,
    output logic [DATA_W-1:0]       dados,
    input  logic                    ack,
    output logic [1:0]              state,
    output logic [$clog2(DEPTH):0]  count,
    output logic [15:0]             sent_cnt,
    output logic                    err,
    input  logic                    err_clr
);

    hs_state_t         state_reg, state_next;
    logic              send_reg, send_next;
    logic [DATA_W-1:0] dados_reg, dados_next;
    logic [15:0]       sent_reg, sent_next;
    logic [DATA_W-1:0] fifo_rdata;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic              phase_hit;

    // in_ready looks only at the registered occupancy, so a full FIFO refuses
    // a push even on a cycle where the FSM pops.
    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;

    hs_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .wdata  (in_data),
        .pop    (pop),
        .rdata  (fifo_rdata),
        .count  (count),
        .full   (fifo_full)
    );

    always_comb begin
        state_next = state_reg;
        send_next  = send_reg;
        dados_next = dados_reg;
        sent_next  = sent_reg;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                // A still-high ack from the previous word blocks a new request.
                if (count != '0 && !ack) begin
                    pop        = 1'b1;
                    dados_next = fifo_rdata;
                    send_next  = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (ack) begin
                    send_next  = 1'b0;
                    state_next = REL;
                end else if (phase_hit) begin
                    send_next  = 1'b0;
                    state_next = DRAIN;
                end
            end
            REL: begin
                if (!ack) begin
                    sent_next  = sent_reg + 16'd1;
                    state_next = IDLE;
                end else if (phase_hit) begin
                    state_next = DRAIN;
                end
            end
            default: begin
                send_next = 1'b0;
                if (!ack) begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            send_reg  <= 1'b0;
            dados_reg <= '0;
            sent_reg  <= '0;
        end else begin
            state_reg <= state_next;
            send_reg  <= send_next;
            dados_reg <= dados_next;
            sent_reg  <= sent_next;
        end
    end

`ifdef HS_LINK_TIMEOUT_EN
    localparam int PW = $clog2(TIMEOUT) + 1;

    logic [PW-1:0] phase_reg;
    logic          err_reg;

    assign phase_hit = (phase_reg == PW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst || state_next != state_reg) begin
            phase_reg <= '0;
        end else if (state_reg == REQ || state_reg == REL) begin
            phase_reg <= phase_reg + 1'b1;
        end
    end

    // Entering DRAIN sets err; that takes priority over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_reg <= 1'b0;
        end else if (state_reg != DRAIN && state_next == DRAIN) begin
            err_reg <= 1'b1;
        end else if (err_clr) begin
            err_reg <= 1'b0;
        end
    end

    assign err = err_reg;
`else
    logic [1:0] unused_cfg;

    assign unused_cfg = {err_clr, TIMEOUT[0]};
    assign phase_hit  = 1'b0;
    assign err        = 1'b0;
`endif

    assign send     = send_reg;
    assign dados    = dados_reg;
    assign state    = state_reg;
    assign sent_cnt = sent_reg;

endmodule

// File: tb/tb_hs_link_tx.sv
// Self-checking bench for hs_link_tx: directed handshake scenarios plus a
// randomized producer/peripheral run against a queue-based link model.
module tb_hs_link_tx;

`ifdef HS_LINK_TIMEOUT_EN
    localparam int TB_TIMEOUT = 8;
`else
    localparam int TB_TIMEOUT = 64;
`endif
    localparam int DEP = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic        send;
    logic [7:0]  dados;
    logic        ack = 1'b0;
    logic [1:0]  state;
    logic [2:0]  count;
    logic [15:0] sent_cnt;
    logic        err;
    logic        err_clr = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    // Link model: words queued for delivery, plus the handshake in flight.
    bit          model_on = 1'b1;
    logic [7:0]  m_q[$];
    logic [7:0]  delivered[$];
    bit          m_send;
    bit          m_busy;
    logic [7:0]  m_dados;
    logic [15:0] m_sent;
    bit          prev_send;
    logic        r_ack;
    int          r_dly;

    always #5 clk = ~clk;

    hs_link_tx #(
        .DATA_W  (8),
        .DEPTH   (DEP),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .send     (send),
        .dados    (dados),
        .ack      (ack),
        .state    (state),
        .count    (count),
        .sent_cnt (sent_cnt),
        .err      (err),
        .err_clr  (err_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_edge(input logic v, input logic [7:0] d, input logic a);
        bit do_push;
        bit do_pop;
        if (!rst) begin
            m_q.delete();
            m_send  = 1'b0;
            m_busy  = 1'b0;
            m_dados = 8'h00;
            m_sent  = 16'd0;
            return;
        end
        do_push = v && (m_q.size() < DEP);
        do_pop  = !m_busy && (m_q.size() != 0) && !a;
        if (m_busy && m_send && a) begin
            m_send = 1'b0;
        end else if (m_busy && !m_send && !a) begin
            m_busy = 1'b0;
            m_sent = m_sent + 16'd1;
        end
        if (do_pop) begin
            m_dados = m_q.pop_front();
            m_send  = 1'b1;
            m_busy  = 1'b1;
        end
        if (do_push) begin
            m_q.push_back(d);
        end
    endtask

    task automatic compare_all();
        logic [1:0] exp_state;
        exp_state = !m_busy ? 2'd0 : (m_send ? 2'd1 : 2'd2);
        check("send", 32'(send), 32'(m_send));
        check("dados", 32'(dados), 32'(m_dados));
        check("count", 32'(count), 32'(m_q.size()));
        check("in_ready", 32'(in_ready), 32'(m_q.size() < DEP));
        check("sent_cnt", 32'(sent_cnt), 32'(m_sent));
        check("err", 32'(err), 32'd0);
        check("state", 32'(state), 32'(exp_state));
    endtask

    task automatic cycle(input logic v, input logic [7:0] d, input logic a, input logic ec);
        in_valid = v;
        in_data  = d;
        ack      = a;
        err_clr  = ec;
        @(posedge clk);
        if (model_on) model_edge(v, d, a);
        #1;
        if (model_on) compare_all();
        if (send && !prev_send) delivered.push_back(dados);
        prev_send = send;
    endtask

    // Peripheral: follows send with a random 0..3 cycle lag, occasionally
    // raising a stale ack pulse while the link is quiet.
    task automatic responder_step();
        if (send != r_ack) begin
            if (r_dly == 0) begin
                r_ack = send;
                r_dly = $urandom_range(0, 3);
            end else begin
                r_dly--;
            end
        end else if (!send && !r_ack && $urandom_range(0, 19) == 0) begin
            r_ack = 1'b1;
        end
    endtask

    task automatic run_auto(input int n);
        for (int i = 0; i < n; i++) begin
            responder_step();
            cycle(1'b0, 8'($urandom), r_ack, 1'b0);
        end
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        r_ack = 1'b0;
        r_dly = 0;
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        rst = 1'b1;
        delivered.delete();
    endtask

    initial begin
        int n;

        // Reset with in_valid held high.
        do_reset();
        check("rst_send", 32'(send), 32'd0);
        check("rst_dados", 32'(dados), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_sent_cnt", 32'(sent_cnt), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // Single word with a two-cycle peripheral.
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("single_send_rise", 32'(send), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("single_dados", 32'(dados), 32'hA5);
        check("single_sent_cnt", 32'(sent_cnt), 32'd1);
        check("single_state", 32'(state), 32'd0);

        // Fill to DEPTH behind a stale ack, then drain in order.
        do_reset();
        for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i), 1'b1, 1'b0);
        check("fill_in_ready", 32'(in_ready), 32'd0);
        cycle(1'b1, 8'h05, 1'b1, 1'b0);
        check("fill_refused_count", 32'(count), 32'd4);
        r_ack = 1'b1;
        run_auto(120);
        check("fill_delivered_n", 32'(delivered.size()), 32'd4);
        for (int i = 0; i < 4 && i < delivered.size(); i++)
            check("fill_order", 32'(delivered[i]), 32'(i + 1));
        check("fill_sent_cnt", 32'(sent_cnt), 32'd4);

        // Push and pop on the same edge at count=2.
        do_reset();
        cycle(1'b1, 8'h11, 1'b1, 1'b0);
        cycle(1'b1, 8'h22, 1'b1, 1'b0);
        cycle(1'b1, 8'h33, 1'b0, 1'b0);
        check("pushpop_count", 32'(count), 32'd2);
        r_ack = 1'b0;
        run_auto(120);
        check("pushpop_delivered_n", 32'(delivered.size()), 32'd3);
        if (delivered.size() == 3) begin
            check("pushpop_w0", 32'(delivered[0]), 32'h11);
            check("pushpop_w1", 32'(delivered[1]), 32'h22);
            check("pushpop_w2", 32'(delivered[2]), 32'h33);
        end

        // Reset while in REL with three words queued.
        do_reset();
        cycle(1'b1, 8'hC1, 1'b0, 1'b0);
        cycle(1'b1, 8'hC2, 1'b0, 1'b0);
        cycle(1'b1, 8'hC3, 1'b0, 1'b0);
        cycle(1'b1, 8'hC4, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("rel_state", 32'(state), 32'd2);
        check("rel_count", 32'(count), 32'd3);
        rst = 1'b0;
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("midrst_state", 32'(state), 32'd0);
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_send", 32'(send), 32'd0);
        rst = 1'b1;
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("midrst_no_xfer", 32'(send), 32'd0);

`ifdef HS_LINK_TIMEOUT_EN
        // Peripheral never answers: request aborts after TIMEOUT cycles.
        do_reset();
        model_on = 1'b0;
        cycle(1'b1, 8'h3C, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("to_send_rise", 32'(send), 32'd1);
        n = 0;
        while (send === 1'b1 && n < 40) begin
            n++;
            cycle(1'b0, 8'h00, 1'b0, 1'b0);
        end
        check("to_send_cycles", 32'(n), 32'd8);
        check("to_err", 32'(err), 32'd1);
        check("to_state_drain", 32'(state), 32'd3);
        check("to_sent_cnt", 32'(sent_cnt), 32'd0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("to_state_idle", 32'(state), 32'd0);
        check("to_err_sticky", 32'(err), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("to_err_clr", 32'(err), 32'd0);
        model_on = 1'b1;
`endif

        // Randomized producer, peripheral and err_clr pulses.
        do_reset();
        n = 0;
        for (int i = 0; i < 800; i++) begin
            responder_step();
            cycle(($urandom_range(0, 2) != 0), 8'($urandom), r_ack,
                  ($urandom_range(0, 15) == 0));
        end
        run_auto(150);
        check("rand_queue_empty", 32'(count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
